// File: rtl/bus_ctrl.sv
// Memory/I-O bus controller: runs one byte or word access per request on a 16-bit
// byte-laned bus, splitting odd-address word accesses into two bus cycles.
module bus_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [19:0] addr,
    input  logic [15:0] wr_data,
    input  logic        we,
    input  logic        m_io,
    input  logic        byteop,
    output logic [15:0] memout,
    output logic        mem_rdy,
    output logic [18:0] bus_adr,
    output logic [15:0] bus_dat_o,
    input  logic [15:0] bus_dat_i,
    output logic [1:0]  bus_sel,
    output logic        bus_we,
    output logic        bus_tga,
    output logic        bus_cyc,
    output logic        bus_stb,
    input  logic        bus_ack
);

    typedef enum logic [1:0] {
        StIdle,
        StLo,
        StHi,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [19:0] addr_q, addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        byteop_q, byteop_d;
    logic        split_q, split_d;
    logic [7:0]  lo_byte_q, lo_byte_d;
    logic [15:0] memout_q, memout_d;
    logic        mem_rdy_q, mem_rdy_d;
    logic [18:0] bus_adr_q, bus_adr_d;
    logic [15:0] bus_dat_o_q, bus_dat_o_d;
    logic [1:0]  bus_sel_q, bus_sel_d;
    logic        bus_we_q, bus_we_d;
    logic        bus_tga_q, bus_tga_d;
    logic        bus_stb_q, bus_stb_d;

    logic [19:0] hi_addr;
    logic [15:0] io_inc;

    // Second half address: I/O space wraps within 16 bits, memory within 20 bits.
    always_comb begin
        io_inc  = addr_q[15:0] + 16'd1;
        hi_addr = bus_tga_q ? {4'h0, io_inc} : (addr_q + 20'd1);
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wr_data_d   = wr_data_q;
        byteop_d    = byteop_q;
        split_d     = split_q;
        lo_byte_d   = lo_byte_q;
        memout_d    = memout_q;
        mem_rdy_d   = 1'b0;
        bus_adr_d   = bus_adr_q;
        bus_dat_o_d = bus_dat_o_q;
        bus_sel_d   = bus_sel_q;
        bus_we_d    = bus_we_q;
        bus_tga_d   = bus_tga_q;
        bus_stb_d   = bus_stb_q;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d   = StLo;
                    addr_d    = addr;
                    wr_data_d = wr_data;
                    byteop_d  = byteop;
                    split_d   = !byteop && addr[0];
                    bus_adr_d = addr[19:1];
                    bus_we_d  = we;
                    bus_tga_d = m_io;
                    bus_stb_d = 1'b1;
                    if (byteop) begin
                        bus_sel_d   = addr[0] ? 2'b10 : 2'b01;
                        bus_dat_o_d = {wr_data[7:0], wr_data[7:0]};
                    end else if (addr[0]) begin
                        bus_sel_d   = 2'b10;
                        bus_dat_o_d = {wr_data[7:0], 8'h00};
                    end else begin
                        bus_sel_d   = 2'b11;
                        bus_dat_o_d = wr_data;
                    end
                end
            end
            StLo: begin
                if (bus_ack) begin
                    if (split_q) begin
                        state_d     = StHi;
                        lo_byte_d   = bus_dat_i[15:8];
                        bus_adr_d   = hi_addr[19:1];
                        bus_sel_d   = 2'b01;
                        bus_dat_o_d = {8'h00, wr_data_q[15:8]};
                    end else begin
                        state_d   = StDone;
                        mem_rdy_d = 1'b1;
                        bus_stb_d = 1'b0;
                        if (!bus_we_q) begin
                            if (!byteop_q) begin
                                memout_d = bus_dat_i;
                            end else if (addr_q[0]) begin
                                memout_d = {8'h00, bus_dat_i[15:8]};
                            end else begin
                                memout_d = {8'h00, bus_dat_i[7:0]};
                            end
                        end
                    end
                end
            end
            StHi: begin
                if (bus_ack) begin
                    state_d   = StDone;
                    mem_rdy_d = 1'b1;
                    bus_stb_d = 1'b0;
                    if (!bus_we_q) begin
                        memout_d = {bus_dat_i[7:0], lo_byte_q};
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= 20'h0;
            wr_data_q   <= 16'h0;
            byteop_q    <= 1'b0;
            split_q     <= 1'b0;
            lo_byte_q   <= 8'h0;
            memout_q    <= 16'h0;
            mem_rdy_q   <= 1'b0;
            bus_adr_q   <= 19'h0;
            bus_dat_o_q <= 16'h0;
            bus_sel_q   <= 2'b00;
            bus_we_q    <= 1'b0;
            bus_tga_q   <= 1'b0;
            bus_stb_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wr_data_q   <= wr_data_d;
            byteop_q    <= byteop_d;
            split_q     <= split_d;
            lo_byte_q   <= lo_byte_d;
            memout_q    <= memout_d;
            mem_rdy_q   <= mem_rdy_d;
            bus_adr_q   <= bus_adr_d;
            bus_dat_o_q <= bus_dat_o_d;
            bus_sel_q   <= bus_sel_d;
            bus_we_q    <= bus_we_d;
            bus_tga_q   <= bus_tga_d;
            bus_stb_q   <= bus_stb_d;
        end
    end

    assign memout    = memout_q;
    assign mem_rdy   = mem_rdy_q;
    assign bus_adr   = bus_adr_q;
    assign bus_dat_o = bus_dat_o_q;
    assign bus_sel   = bus_sel_q;
    assign bus_we    = bus_we_q;
    assign bus_tga   = bus_tga_q;
    assign bus_stb   = bus_stb_q;
    assign bus_cyc   = bus_stb_q;

endmodule

// File: tb/tb_bus_ctrl.sv
// Directed bench for bus_ctrl: table of single-cycle accesses plus split, wait-state
// and mid-access reset sequences.
module tb_bus_ctrl;

    logic        clk;
    logic        rst;
    logic        req;
    logic [19:0] addr;
    logic [15:0] wr_data;
    logic        we;
    logic        m_io;
    logic        byteop;
    logic [15:0] memout;
    logic        mem_rdy;
    logic [18:0] bus_adr;
    logic [15:0] bus_dat_o;
    logic [15:0] bus_dat_i;
    logic [1:0]  bus_sel;
    logic        bus_we;
    logic        bus_tga;
    logic        bus_cyc;
    logic        bus_stb;
    logic        bus_ack;

    bus_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .addr     (addr),
        .wr_data  (wr_data),
        .we       (we),
        .m_io     (m_io),
        .byteop   (byteop),
        .memout   (memout),
        .mem_rdy  (mem_rdy),
        .bus_adr  (bus_adr),
        .bus_dat_o(bus_dat_o),
        .bus_dat_i(bus_dat_i),
        .bus_sel  (bus_sel),
        .bus_we   (bus_we),
        .bus_tga  (bus_tga),
        .bus_cyc  (bus_cyc),
        .bus_stb  (bus_stb),
        .bus_ack  (bus_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int rdy_cnt = 0;

    always @(negedge clk) if (mem_rdy === 1'b1) rdy_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [19:0] addr;
        logic [15:0] wd;
        logic        we;
        logic        mio;
        logic        bop;
        logic [15:0] rd;
        logic [18:0] adr;
        logic [1:0]  sel;
        logic [15:0] dato;
        logic [15:0] mout;
    } vec_t;

    vec_t vecs[7];

    task automatic drive_req(input logic [19:0] a, input logic [15:0] d, input logic w,
                             input logic io, input logic b);
        req     = 1'b1;
        addr    = a;
        wr_data = d;
        we      = w;
        m_io    = io;
        byteop  = b;
        bus_ack = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int start;
        @(negedge clk);
        drive_req(v.addr, v.wd, v.we, v.mio, v.bop);
        @(posedge clk); #1;
        start = rdy_cnt;
        chk($sformatf("v%0d stb", idx), {31'd0, bus_stb & bus_cyc}, 32'd1);
        chk($sformatf("v%0d adr", idx), {13'd0, bus_adr}, {13'd0, v.adr});
        chk($sformatf("v%0d sel", idx), {30'd0, bus_sel}, {30'd0, v.sel});
        chk($sformatf("v%0d dat_o", idx), {16'd0, bus_dat_o}, {16'd0, v.dato});
        chk($sformatf("v%0d we/tga", idx), {30'd0, bus_we, bus_tga}, {30'd0, v.we, v.mio});
        @(negedge clk);
        // Scramble non-req inputs: they must have been latched already.
        addr      = ~v.addr;
        wr_data   = ~v.wd;
        we        = ~v.we;
        m_io      = ~v.mio;
        byteop    = ~v.bop;
        bus_dat_i = v.rd;
        bus_ack   = 1'b1;
        @(posedge clk); #1;
        chk($sformatf("v%0d rdy", idx), {31'd0, mem_rdy}, 32'd1);
        chk($sformatf("v%0d stb off", idx), {31'd0, bus_stb | bus_cyc}, 32'd0);
        chk($sformatf("v%0d memout", idx), {16'd0, memout}, {16'd0, v.mout});
        @(negedge clk);
        req     = 1'b0;
        bus_ack = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("v%0d rdy pulse", idx), rdy_cnt - start, 32'd1);
        chk($sformatf("v%0d rdy low", idx), {31'd0, mem_rdy}, 32'd0);
    endtask

    initial begin
        int start;
        req = 0; addr = 0; wr_data = 0; we = 0; m_io = 0; byteop = 0;
        bus_dat_i = 0; bus_ack = 0;
        rst = 1'b1;
        //           addr      wd        we mio bop rd       adr       sel    dato      mout
        vecs[0] = '{20'h12344, 16'h1111, 0, 0, 0, 16'hBEEF, 19'h091A2, 2'b11, 16'h1111, 16'hBEEF};
        vecs[1] = '{20'h003F9, 16'h775A, 1, 1, 1, 16'h0000, 19'h001FC, 2'b10, 16'h5A5A, 16'hBEEF};
        vecs[2] = '{20'h00100, 16'h0000, 0, 0, 1, 16'h12C3, 19'h00080, 2'b01, 16'h0000, 16'h00C3};
        vecs[3] = '{20'h00101, 16'h0000, 0, 0, 1, 16'h12C3, 19'h00080, 2'b10, 16'h0000, 16'h0012};
        vecs[4] = '{20'h80000, 16'hCAFE, 1, 0, 0, 16'hFFFF, 19'h40000, 2'b11, 16'hCAFE, 16'h0012};
        vecs[5] = '{20'h0ABCE, 16'h0000, 0, 1, 0, 16'h5566, 19'h055E7, 2'b11, 16'h0000, 16'h5566};
        vecs[6] = '{20'h00002, 16'h99A5, 1, 0, 1, 16'h0000, 19'h00001, 2'b01, 16'hA5A5, 16'h5566};

        #12;
        chk("reset rdy/stb/cyc", {29'd0, mem_rdy, bus_stb, bus_cyc}, 32'd0);
        chk("reset we/tga/sel", {28'd0, bus_we, bus_tga, bus_sel}, 32'd0);
        chk("reset adr", {13'd0, bus_adr}, 32'd0);
        chk("reset dat_o/memout", {bus_dat_o, memout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Split word read at FFFFF, address wraps to 00000.
        @(negedge clk);
        drive_req(20'hFFFFF, 16'h0000, 0, 0, 0);
        start = rdy_cnt;
        @(posedge clk); #1;
        chk("splitrd lo adr", {13'd0, bus_adr}, 32'h7FFFF);
        chk("splitrd lo sel", {30'd0, bus_sel}, 32'd2);
        chk("splitrd lo stb", {31'd0, bus_stb}, 32'd1);
        @(negedge clk);
        req = 1'b0; bus_dat_i = 16'h3400; bus_ack = 1'b1;
        @(posedge clk); #1;
        chk("splitrd hi adr", {13'd0, bus_adr}, 32'h0);
        chk("splitrd hi sel", {30'd0, bus_sel}, 32'd1);
        chk("splitrd hi stb", {31'd0, bus_stb & bus_cyc}, 32'd1);
        chk("splitrd hi rdy", {31'd0, mem_rdy}, 32'd0);
        @(negedge clk);
        bus_dat_i = 16'h0012;
        @(posedge clk); #1;
        chk("splitrd rdy", {31'd0, mem_rdy}, 32'd1);
        chk("splitrd memout", {16'd0, memout}, 32'h1234);
        @(negedge clk);
        bus_ack = 1'b0;
        @(posedge clk); #1;
        chk("splitrd pulses", rdy_cnt - start, 32'd1);

        // Split word write in I/O space at 0FFFF, wraps within 16 bits.
        @(negedge clk);
        drive_req(20'h0FFFF, 16'hA1B2, 1, 1, 0);
        @(posedge clk); #1;
        chk("splitwr lo adr", {13'd0, bus_adr}, 32'h07FFF);
        chk("splitwr lo sel/we/tga", {28'd0, bus_sel, bus_we, bus_tga}, 32'hB);
        chk("splitwr lo dat", {16'd0, bus_dat_o}, 32'hB200);
        @(negedge clk);
        bus_ack = 1'b1;
        @(posedge clk); #1;
        chk("splitwr hi adr", {13'd0, bus_adr}, 32'h0);
        chk("splitwr hi sel", {30'd0, bus_sel}, 32'd1);
        chk("splitwr hi dat", {16'd0, bus_dat_o}, 32'h00A1);
        @(negedge clk);
        req = 1'b0;
        @(posedge clk); #1;
        chk("splitwr rdy", {31'd0, mem_rdy}, 32'd1);
        chk("splitwr memout", {16'd0, memout}, 32'h1234);
        @(negedge clk);
        bus_ack = 1'b0;

        // Byte read at 00001 with 3 wait states, req dropped early, then stray acks.
        @(negedge clk);
        drive_req(20'h00001, 16'h0000, 0, 0, 1);
        start = rdy_cnt;
        @(posedge clk); #1;
        chk("wait sel", {30'd0, bus_sel}, 32'd2);
        @(negedge clk);
        req = 1'b0;
        for (int w = 0; w < 3; w++) begin
            @(posedge clk); #1;
            chk($sformatf("wait%0d stb", w), {30'd0, bus_stb, mem_rdy}, 32'd2);
            @(negedge clk);
        end
        bus_dat_i = 16'h7E11; bus_ack = 1'b1;
        @(posedge clk); #1;
        chk("wait rdy", {31'd0, mem_rdy}, 32'd1);
        chk("wait memout", {16'd0, memout}, 32'h007E);
        bus_dat_i = 16'hDEAD;
        for (int w = 0; w < 3; w++) begin
            @(posedge clk); #1;
            chk($sformatf("stray%0d", w), {30'd0, bus_stb, mem_rdy}, 32'd0);
        end
        chk("wait pulses", rdy_cnt - start, 32'd1);
        chk("stray memout", {16'd0, memout}, 32'h007E);
        @(negedge clk);
        bus_ack = 1'b0;

        // Asynchronous reset while in the second half of a split read.
        @(negedge clk);
        drive_req(20'h00003, 16'h0000, 0, 0, 0);
        start = rdy_cnt;
        @(posedge clk); #1;
        @(negedge clk);
        req = 1'b0; bus_ack = 1'b1; bus_dat_i = 16'h5500;
        @(posedge clk); #1;
        chk("rst pre stb", {31'd0, bus_stb}, 32'd1);
        bus_ack = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst async stb/cyc", {30'd0, bus_stb, bus_cyc}, 32'd0);
        chk("rst async memout", {16'd0, memout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst no rdy", rdy_cnt - start, 32'd0);
        vecs[0] = '{20'h00010, 16'h0000, 0, 0, 0, 16'h4321, 19'h00008, 2'b11, 16'h0000, 16'h4321};
        run_vec(vecs[0], 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
